// File: rtl/kws_pkg.sv
// Shared widths, sentinel value and smoothing-state encoding for the KWS decider.
package kws_pkg;

  localparam int LOGIT_W = 32;
  localparam int CLS_W   = 5;

  // Most negative signed logit; any real logit except this value beats it.
  localparam logic [LOGIT_W-1:0] NEG_INF = 32'h8000_0000;

  typedef enum logic [1:0] {
    SM_IDLE,
    SM_TRACK,
    SM_FIRED
  } sm_state_e;

endpackage

// File: rtl/kws_top2_tracker.sv
// Keeps the best and second-best logit of the current frame plus the class of the best.
// The updated values are also exported combinationally so the final logit of a frame
// can be captured in the same cycle that the trackers are reinitialised.
module kws_top2_tracker
  import kws_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      init,
  input  logic                      load,
  input  logic signed [LOGIT_W-1:0] data,
  input  logic        [CLS_W-1:0]   idx,
  output logic signed [LOGIT_W-1:0] best_q,
  output logic signed [LOGIT_W-1:0] second_q,
  output logic        [CLS_W-1:0]   best_idx_q,
  output logic signed [LOGIT_W-1:0] upd_best,
  output logic signed [LOGIT_W-1:0] upd_second,
  output logic        [CLS_W-1:0]   upd_idx
);

  logic signed [LOGIT_W-1:0] best_d;
  logic signed [LOGIT_W-1:0] second_d;
  logic        [CLS_W-1:0]   best_idx_d;

  // Strict compares keep the earlier arrival as winner; an equal value drops to second.
  always_comb begin
    upd_best   = best_q;
    upd_second = second_q;
    upd_idx    = best_idx_q;
    if (data > best_q) begin
      upd_second = best_q;
      upd_best   = data;
      upd_idx    = idx;
    end else if (data > second_q) begin
      upd_second = data;
    end
  end

  // Frame start reloads the sentinel; otherwise an accepted logit commits the update.
  always_comb begin
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    if (init) begin
      best_d     = NEG_INF;
      second_d   = NEG_INF;
      best_idx_d = '0;
    end else if (load) begin
      best_d     = upd_best;
      second_d   = upd_second;
      best_idx_d = upd_idx;
    end
  end

  // Tracker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q     <= NEG_INF;
      second_q   <= NEG_INF;
      best_idx_q <= '0;
    end else begin
      best_q     <= best_d;
      second_q   <= second_d;
      best_idx_q <= best_idx_d;
    end
  end

endmodule

// File: rtl/kws_argmax_decider.sv
// Final KWS stage: frames incoming logits, reports the winner with its margin two
// cycles after the last logit, and smooths confident winners into a detect pulse.
module kws_argmax_decider
  import kws_pkg::*;
#(
  parameter int                 NUM_CLASSES = 12,
  parameter logic [LOGIT_W-1:0] MARGIN_THR  = 32'd1000,
  parameter int                 HOLD_FRAMES = 3
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               soft_clr,
  input  logic               in_valid,
  input  logic [LOGIT_W-1:0] in_data,
  input  logic [9:0]         in_addr,
  output logic               result_valid,
  output logic [CLS_W-1:0]   result_class,
  output logic [LOGIT_W-1:0] result_score,
  output logic [LOGIT_W-1:0] result_margin,
  output logic               kw_detect,
  output logic [CLS_W-1:0]   kw_class,
  output logic               addr_err
);

  localparam logic [9:0] ADDR_LIM = 10'(NUM_CLASSES);
  localparam logic [5:0] LAST_CNT = 6'(NUM_CLASSES - 1);
  localparam logic [3:0] HOLD_CNT = 4'(HOLD_FRAMES);

  logic clr;
  logic addr_ok;
  logic accept;
  logic frame_complete;

  logic signed [LOGIT_W-1:0] trk_best, trk_second, upd_best, upd_second;
  logic        [CLS_W-1:0]   trk_idx, upd_idx;

  logic [5:0]                frame_cnt_q, frame_cnt_d;
  logic                      addr_err_q, addr_err_d;
  logic                      dec_valid_q, dec_valid_d;
  logic signed [LOGIT_W-1:0] dec_best_q, dec_best_d;
  logic signed [LOGIT_W-1:0] dec_second_q, dec_second_d;
  logic        [CLS_W-1:0]   dec_idx_q, dec_idx_d;
  logic                      result_valid_q, result_valid_d;
  logic        [CLS_W-1:0]   result_class_q, result_class_d;
  logic        [LOGIT_W-1:0] result_score_q, result_score_d;
  logic        [LOGIT_W-1:0] result_margin_q, result_margin_d;

  logic [LOGIT_W-1:0] margin;
  logic               confident;

  sm_state_e        state_q, state_d;
  logic [3:0]       streak_q, streak_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  logic             kw_detect_q, kw_detect_d;
  logic [CLS_W-1:0] kw_class_q, kw_class_d;

  assign clr            = wb_rst_i | soft_clr;
  assign addr_ok        = (in_addr < ADDR_LIM);
  assign accept         = in_valid & addr_ok;
  assign frame_complete = accept & (frame_cnt_q == LAST_CNT);

  kws_top2_tracker u_tracker (
    .clk        (wb_clk_i),
    .rst        (clr),
    .init       (frame_complete),
    .load       (accept),
    .data       (in_data),
    .idx        (in_addr[CLS_W-1:0]),
    .best_q     (trk_best),
    .second_q   (trk_second),
    .best_idx_q (trk_idx),
    .upd_best   (upd_best),
    .upd_second (upd_second),
    .upd_idx    (upd_idx)
  );

  // best >= second always holds, so the 33-bit difference is non-negative and its low
  // 32 bits equal the wrapping 32-bit difference.
  assign margin    = dec_best_q - dec_second_q;
  assign confident = (margin >= MARGIN_THR);

  // Frame counting, snapshot of the finished frame and the report stage.
  always_comb begin
    frame_cnt_d     = frame_cnt_q;
    addr_err_d      = addr_err_q | (in_valid & ~addr_ok);
    dec_valid_d     = frame_complete;
    dec_best_d      = dec_best_q;
    dec_second_d    = dec_second_q;
    dec_idx_d       = dec_idx_q;
    result_valid_d  = dec_valid_q;
    result_class_d  = result_class_q;
    result_score_d  = result_score_q;
    result_margin_d = result_margin_q;
    if (accept) begin
      frame_cnt_d = frame_complete ? 6'd0 : frame_cnt_q + 6'd1;
    end
    if (frame_complete) begin
      dec_best_d   = upd_best;
      dec_second_d = upd_second;
      dec_idx_d    = upd_idx;
    end
    if (dec_valid_q) begin
      result_class_d  = dec_idx_q;
      result_score_d  = dec_best_q;
      result_margin_d = margin;
    end
  end

  // Datapath registers.
  always_ff @(posedge wb_clk_i) begin
    if (clr) begin
      frame_cnt_q     <= '0;
      addr_err_q      <= 1'b0;
      dec_valid_q     <= 1'b0;
      dec_best_q      <= NEG_INF;
      dec_second_q    <= NEG_INF;
      dec_idx_q       <= '0;
      result_valid_q  <= 1'b0;
      result_class_q  <= '0;
      result_score_q  <= '0;
      result_margin_q <= '0;
    end else begin
      frame_cnt_q     <= frame_cnt_d;
      addr_err_q      <= addr_err_d;
      dec_valid_q     <= dec_valid_d;
      dec_best_q      <= dec_best_d;
      dec_second_q    <= dec_second_d;
      dec_idx_q       <= dec_idx_d;
      result_valid_q  <= result_valid_d;
      result_class_q  <= result_class_d;
      result_score_q  <= result_score_d;
      result_margin_q <= result_margin_d;
    end
  end

  // Smoothing FSM, stepped once per decided frame; the detect pulse lines up with result_valid.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    cls_d       = cls_q;
    kw_detect_d = 1'b0;
    kw_class_d  = kw_class_q;
    if (dec_valid_q) begin
      if (!confident) begin
        state_d  = SM_IDLE;
        streak_d = '0;
      end else begin
        unique case (state_q)
          SM_IDLE: begin
            state_d  = SM_TRACK;
            streak_d = 4'd1;
            cls_d    = dec_idx_q;
          end
          SM_TRACK: begin
            if (dec_idx_q == cls_q) begin
              streak_d = streak_q + 4'd1;
            end else begin
              streak_d = 4'd1;
              cls_d    = dec_idx_q;
            end
          end
          SM_FIRED: begin
            if (dec_idx_q != cls_q) begin
              state_d  = SM_TRACK;
              streak_d = 4'd1;
              cls_d    = dec_idx_q;
            end
          end
          default: state_d = SM_IDLE;
        endcase
        if ((state_d == SM_TRACK) && (streak_d == HOLD_CNT)) begin
          state_d     = SM_FIRED;
          kw_detect_d = 1'b1;
          kw_class_d  = cls_d;
        end
      end
    end
  end

  // Smoothing state register.
  always_ff @(posedge wb_clk_i) begin
    if (clr) begin
      state_q     <= SM_IDLE;
      streak_q    <= '0;
      cls_q       <= '0;
      kw_detect_q <= 1'b0;
      kw_class_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      cls_q       <= cls_d;
      kw_detect_q <= kw_detect_d;
      kw_class_q  <= kw_class_d;
    end
  end

  assign result_valid  = result_valid_q;
  assign result_class  = result_class_q;
  assign result_score  = result_score_q;
  assign result_margin = result_margin_q;
  assign kw_detect     = kw_detect_q;
  assign kw_class      = kw_class_q;
  assign addr_err      = addr_err_q;

endmodule
